// File: rtl/pc_sequencer_if.sv
// pc_stk_if: command port between the program-counter sequencer and the
// two-level return-address stack.
//   stk_cmd  : stack command (PUSH / POP, anything else holds)
//   stk_data : value to push, always pc+1
//   stk_top  : current top of the stack, pre-edge value
// master = sequencer side, slave = stack side.
interface pc_stk_if #(
    parameter int unsigned PC_WIDTH = 11
);
    logic [1:0]          stk_cmd;
    logic [PC_WIDTH-1:0] stk_data;
    logic [PC_WIDTH-1:0] stk_top;

    modport master (output stk_cmd, output stk_data, input stk_top);
    modport slave  (input stk_cmd, input stk_data, output stk_top);
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the PIC16C5x core.
// Owns the PC, decodes the control-flow class of the executing instruction,
// drives the return-stack command port, manages the one-cycle fetch flush
// after taken branches, and tracks stack depth with sticky ovf/unf flags.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   en_i            : instruction-cycle strobe
//   op_i            : control-flow class (NEXT/SKIP/GOTO/CALL/RET/PCLW/SLEEP)
//   target_i        : GOTO/CALL literal
//   page_i          : STATUS PA1:PA0, supplies PC[10:9] on branches
//   pcl_data_i      : ALU result written to PCL
//   wake_i          : wake-up request, sampled in SLEEP
//   stk             : stack command port (master)
//   pc_o            : fetch address
//   flush_o         : execute-slot instruction must be treated as NOP
//   depth_o         : valid stack entries 0..2
//   stk_ovf_o/unf_o : sticky overflow / underflow
module pc_sequencer #(
    parameter int unsigned         PC_WIDTH  = 11,
    parameter logic [PC_WIDTH-1:0] RESET_VEC = PC_WIDTH'(11'h7FF)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_i,
    input  logic [2:0]          op_i,
    input  logic [8:0]          target_i,
    input  logic [1:0]          page_i,
    input  logic [7:0]          pcl_data_i,
    input  logic                wake_i,
    pc_stk_if.master            stk,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic                flush_o,
    output logic [1:0]          depth_o,
    output logic                stk_ovf_o,
    output logic                stk_unf_o
);
    // Stack command encodings shared with the stack (define.v values).
    localparam logic [1:0] STK_HOLD = 2'b00;
    localparam logic [1:0] STK_PUSH = 2'b01;
    localparam logic [1:0] STK_POP  = 2'b10;

    localparam logic [2:0] OP_SKIP  = 3'd1;
    localparam logic [2:0] OP_GOTO  = 3'd2;
    localparam logic [2:0] OP_CALL  = 3'd3;
    localparam logic [2:0] OP_RET   = 3'd4;
    localparam logic [2:0] OP_PCLW  = 3'd5;
    localparam logic [2:0] OP_SLEEP = 3'd6;

    localparam logic [1:0] ST_FLUSH = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_SLEEP = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [1:0]          depth_q, depth_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic [1:0]          cmd;

    logic [PC_WIDTH-1:0] pc_inc;
    logic [10:0]         br_goto, br_call, br_pclw;

    assign pc_inc  = pc_q + PC_WIDTH'(1);
    // Branch targets are 11 bits; any PC bits above 10 are zero-filled.
    assign br_goto = {page_i, target_i};
    assign br_call = {page_i, 1'b0, target_i[7:0]};
    assign br_pclw = {page_i, 1'b0, pcl_data_i};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        cmd     = STK_HOLD;
        case (state_q)
            ST_FLUSH: begin
                pc_d    = pc_inc;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                case (op_i)
                    OP_SKIP: begin
                        pc_d    = pc_inc;
                        state_d = ST_FLUSH;
                    end
                    OP_GOTO: begin
                        pc_d    = PC_WIDTH'(br_goto);
                        state_d = ST_FLUSH;
                    end
                    OP_CALL: begin
                        pc_d    = PC_WIDTH'(br_call);
                        cmd     = STK_PUSH;
                        state_d = ST_FLUSH;
                        // A full stack drops its oldest entry; depth saturates.
                        if (depth_q == 2'd2) ovf_d = 1'b1;
                        else                 depth_d = depth_q + 2'd1;
                    end
                    OP_RET: begin
                        pc_d    = stk.stk_top;
                        cmd     = STK_POP;
                        state_d = ST_FLUSH;
                        if (depth_q == 2'd0) unf_d = 1'b1;
                        else                 depth_d = depth_q - 2'd1;
                    end
                    OP_PCLW: begin
                        pc_d    = PC_WIDTH'(br_pclw);
                        state_d = ST_FLUSH;
                    end
                    OP_SLEEP: state_d = ST_SLEEP;
                    default:  pc_d = pc_inc;   // NEXT and the unused code 7
                endcase
            end
            ST_SLEEP: begin
                // Fetch word at pc stays valid, so waking needs no flush.
                if (wake_i) state_d = ST_RUN;
            end
            default: state_d = ST_FLUSH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FLUSH;
            pc_q    <= RESET_VEC;
            depth_q <= 2'd0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (en_i) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack commits on the same edge as pc, so the command is only live
    // when that edge will actually be taken.
    assign stk.stk_cmd  = (en_i && !rst) ? cmd : STK_HOLD;
    assign stk.stk_data = pc_inc;

    assign pc_o      = pc_q;
    assign flush_o   = (state_q != ST_RUN);
    assign depth_o   = depth_q;
    assign stk_ovf_o = ovf_q;
    assign stk_unf_o = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural
// model of the sequencer.
module tb_pc_sequencer;
    localparam int PCMOD = 2048;
    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] PUSH = 2'b01;
    localparam logic [1:0] POP  = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  op;
    logic [8:0]  target;
    logic [1:0]  page;
    logic [7:0]  pcl_data;
    logic        wake;
    logic [10:0] pc_o;
    logic        flush_o;
    logic [1:0]  depth_o;
    logic        ovf_o, unf_o;

    pc_stk_if #(.PC_WIDTH(11)) stk_bus();

    pc_sequencer #(.PC_WIDTH(11), .RESET_VEC(11'h7FF)) dut (
        .clk(clk), .rst(rst), .en_i(en), .op_i(op), .target_i(target),
        .page_i(page), .pcl_data_i(pcl_data), .wake_i(wake), .stk(stk_bus),
        .pc_o(pc_o), .flush_o(flush_o), .depth_o(depth_o),
        .stk_ovf_o(ovf_o), .stk_unf_o(unf_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;
    bit done    = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_pc;
    int m_depth;
    bit m_squash;  // next instruction is thrown away
    bit m_asleep;
    bit m_ovf, m_unf;

    always @(posedge clk) begin
        started <= 1'b1;
        if (rst) begin
            m_pc <= 'h7FF; m_squash <= 1'b1; m_asleep <= 1'b0;
            m_depth <= 0; m_ovf <= 1'b0; m_unf <= 1'b0;
        end else if (en) begin
            if (m_asleep) begin
                if (wake) m_asleep <= 1'b0;
            end else if (m_squash) begin
                m_pc <= (m_pc + 1) % PCMOD;
                m_squash <= 1'b0;
            end else begin
                m_squash <= (op >= 1 && op <= 5);
                m_asleep <= (op == 6);
                case (op)
                    1: m_pc <= (m_pc + 1) % PCMOD;
                    2: m_pc <= page * 512 + target;
                    3: begin
                        m_pc <= page * 512 + (target % 256);
                        if (m_depth == 2) m_ovf <= 1'b1;
                        else m_depth <= m_depth + 1;
                    end
                    4: begin
                        m_pc <= int'(stk_bus.stk_top);
                        if (m_depth == 0) m_unf <= 1'b1;
                        else m_depth <= m_depth - 1;
                    end
                    5: m_pc <= page * 512 + pcl_data;
                    6: ;
                    default: m_pc <= (m_pc + 1) % PCMOD;
                endcase
            end
        end
    end

    function automatic int exp_cmd();
        if (rst || !en || m_squash || m_asleep) return HOLD;
        if (op == 3) return PUSH;
        if (op == 4) return POP;
        return HOLD;
    endfunction

    always @(negedge clk) begin
        if (started && !done) begin
            chk("pc", int'(pc_o), m_pc);
            chk("flush", int'(flush_o), int'(m_squash || m_asleep));
            chk("depth", int'(depth_o), m_depth);
            chk("ovf", int'(ovf_o), int'(m_ovf));
            chk("unf", int'(unf_o), int'(m_unf));
            chk("stk_cmd", int'(stk_bus.stk_cmd), exp_cmd());
            chk("stk_data", int'(stk_bus.stk_data), (m_pc + 1) % PCMOD);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic setin(input logic [2:0] o, input logic [8:0] t,
                         input logic [1:0] p, input logic [7:0] d,
                         input logic w, input logic [10:0] top);
        en = 1'b1; op = o; target = t; page = p; pcl_data = d; wake = w;
        stk_bus.stk_top = top;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic go(input logic [2:0] o, input logic [8:0] t,
                      input logic [1:0] p);
        setin(o, t, p, 8'h00, 1'b0, 11'h000);
        tick();
    endtask

    // Literal pins both the DUT and the model.
    task automatic lit(input string name, input int dut_v, input int mdl_v,
                       input int exp);
        chk(name, dut_v, exp);
        chk({"model_", name}, mdl_v, exp);
    endtask

    initial begin
        rst = 1'b1;
        setin(3'd0, 9'h0, 2'd0, 8'h0, 1'b0, 11'h0);
        tick(); tick();
        lit("rst_pc", int'(pc_o), m_pc, 'h7FF);
        chk("rst_flush", int'(flush_o), 1);
        chk("rst_depth", int'(depth_o), 0);
        chk("rst_cmd", int'(stk_bus.stk_cmd), HOLD);
        chk("rst_data", int'(stk_bus.stk_data), 'h000);
        rst = 1'b0;
        go(3'd0, 9'h0, 2'd0);
        lit("first_pc", int'(pc_o), m_pc, 'h000);
        chk("first_flush", int'(flush_o), 0);

        // CALL from 0x012
        go(3'd2, 9'h011, 2'd0);
        go(3'd0, 9'h0, 2'd0);
        chk("pre_call_pc", int'(pc_o), 'h012);
        setin(3'd3, 9'h0A5, 2'd1, 8'h0, 1'b0, 11'h0);
        #1;
        chk("call_cmd", int'(stk_bus.stk_cmd), PUSH);
        chk("call_data", int'(stk_bus.stk_data), 'h013);
        tick();
        lit("call_pc", int'(pc_o), m_pc, 'h2A5);
        chk("call_flush", int'(flush_o), 1);
        lit("call_depth", int'(depth_o), m_depth, 1);
        go(3'd0, 9'h0, 2'd0);
        chk("after_call_pc", int'(pc_o), 'h2A6);

        // two more CALLs -> overflow
        go(3'd3, 9'h020, 2'd0); go(3'd0, 9'h0, 2'd0);
        go(3'd3, 9'h020, 2'd0);
        lit("ovf_depth", int'(depth_o), m_depth, 2);
        lit("ovf_flag", int'(ovf_o), int'(m_ovf), 1);
        go(3'd0, 9'h0, 2'd0);
        setin(3'd4, 9'h0, 2'd0, 8'h0, 1'b0, 11'h150);
        #1;
        chk("ret_cmd", int'(stk_bus.stk_cmd), POP);
        tick();
        lit("ret_pc", int'(pc_o), m_pc, 'h150);
        chk("ret_depth", int'(depth_o), 1);
        go(3'd0, 9'h0, 2'd0);

        // drain and underflow
        setin(3'd4, 9'h0, 2'd0, 8'h0, 1'b0, 11'h060); tick();
        go(3'd0, 9'h0, 2'd0);
        setin(3'd4, 9'h0, 2'd0, 8'h0, 1'b0, 11'h033); tick();
        lit("unf_pc", int'(pc_o), m_pc, 'h033);
        lit("unf_flag", int'(unf_o), int'(m_unf), 1);
        chk("unf_depth", int'(depth_o), 0);
        go(3'd0, 9'h0, 2'd0);

        // SKIP squashes a CALL
        go(3'd2, 9'h03F, 2'd0); go(3'd0, 9'h0, 2'd0);
        chk("pre_skip_pc", int'(pc_o), 'h040);
        go(3'd1, 9'h0, 2'd0);
        chk("skip_pc", int'(pc_o), 'h041);
        chk("skip_flush", int'(flush_o), 1);
        setin(3'd3, 9'h055, 2'd2, 8'h0, 1'b0, 11'h0);
        #1;
        chk("squash_cmd", int'(stk_bus.stk_cmd), HOLD);
        tick();
        chk("squash_pc", int'(pc_o), 'h042);
        chk("squash_depth", int'(depth_o), 0);

        // PCLW
        setin(3'd5, 9'h0, 2'd3, 8'h3C, 1'b0, 11'h0); tick();
        lit("pclw_pc", int'(pc_o), m_pc, 'h63C);
        chk("pclw_flush", int'(flush_o), 1);
        go(3'd0, 9'h0, 2'd0);

        // SLEEP / wake
        go(3'd2, 9'h0FF, 2'd0); go(3'd0, 9'h0, 2'd0);
        go(3'd6, 9'h0, 2'd0);
        chk("sleep_pc", int'(pc_o), 'h100);
        chk("sleep_flush", int'(flush_o), 1);
        for (int i = 0; i < 5; i++) go(3'd3, 9'h012, 2'd1);
        chk("asleep_pc", int'(pc_o), 'h100);
        chk("asleep_depth", int'(depth_o), 0);
        setin(3'd0, 9'h0, 2'd0, 8'h0, 1'b1, 11'h0); tick();
        chk("wake_flush", int'(flush_o), 0);
        chk("wake_pc", int'(pc_o), 'h100);
        chk("unf_sticky", int'(unf_o), 1);

        // enable gating
        setin(3'd3, 9'h012, 2'd1, 8'h0, 1'b0, 11'h0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("gate_cmd", int'(stk_bus.stk_cmd), HOLD);
            tick();
        end
        chk("gate_pc", int'(pc_o), 'h100);
        chk("gate_flush", int'(flush_o), 0);

        // reset during CALL
        setin(3'd3, 9'h012, 2'd1, 8'h0, 1'b0, 11'h0);
        rst = 1'b1;
        #1;
        chk("rstcall_cmd", int'(stk_bus.stk_cmd), HOLD);
        tick();
        chk("rstcall_pc", int'(pc_o), 'h7FF);
        chk("rstcall_depth", int'(depth_o), 0);
        chk("rstcall_unf", int'(unf_o), 0);
        rst = 1'b0;

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 99) == 0);
            en       = ($urandom_range(0, 99) < 85);
            op       = 3'($urandom_range(0, 7));
            target   = 9'($urandom_range(0, 511));
            page     = 2'($urandom_range(0, 3));
            pcl_data = 8'($urandom_range(0, 255));
            wake     = ($urandom_range(0, 3) == 0);
            stk_bus.stk_top = 11'($urandom_range(0, 2047));
            tick();
        end

        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the PIC16C5x core. It owns the PC register and decodes the control-flow class of the executing instruction (next, skip, GOTO, CALL, RETLW, PCL write, SLEEP). It drives the two-level return-address stack through its command port and manages the two-stage fetch/execute flush. It also tracks stack depth and flags overflow and underflow. It sits between the instruction decoder/ALU and the stack.

## Interface
- `PC_WIDTH`, default 11: PC width; legal range 11..13. Bits above 10 are always loaded with 0 on branch.
- `RESET_VEC`, default 11'h7FF: PC value loaded by reset.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset; one clock, and reset is synchronous and active-high.
- `en`  in  1  instruction-cycle strobe; state advances only on edges where `en`=1.
- `op`  in  3  control-flow class of the executing instruction: 0 NEXT, 1 SKIP, 2 GOTO, 3 CALL, 4 RET (RETLW), 5 PCLW, 6 SLEEP, 7 is treated as NEXT.
- `target`  in  9  literal: GOTO uses [8:0]; CALL uses [7:0].
- `page`  in  2  STATUS PA1:PA0; supplies PC[10:9] on GOTO, CALL and PCLW.
- `pcl_data`  in  8  ALU result written to PCL.
- `wake`  in  1  wake-up request, sampled in SLEEP.
- `stk_top`  in  PC_WIDTH  current top of the return stack, pre-edge value.
- `stk_cmd`  out  2  stack command: `STK_PUSH`/`STK_POP` from define.v; any other value means hold.
- `stk_data`  out  PC_WIDTH  value to push, always pc+1.
- `pc`  out  PC_WIDTH  address being fetched.
- `flush`  out  1  the instruction currently in the execute slot must be executed as NOP.
- `depth`  out  2  number of valid stack entries, 0..2.
- `stk_ovf`, `stk_unf`  out  1 each  sticky overflow and underflow flags; cleared only by `rst`.

## Operation
- The sequencer has three states: FLUSH, RUN and SLEEP. `flush` is 1 in FLUSH and in SLEEP.
- In FLUSH, on `en`:
  - `op` is ignored.
  - pc <= pc+1.
  - State goes to RUN.
- In RUN, on `en`, by `op`:
  - NEXT: pc <= pc+1.
  - SKIP: pc <= pc+1; state goes to FLUSH.
  - GOTO: pc <= {page, target[8:0]}; state goes to FLUSH.
  - CALL: pc <= {page, 1'b0, target[7:0]}; `stk_cmd`=PUSH; state goes to FLUSH.
  - RET: pc <= stk_top; `stk_cmd`=POP; state goes to FLUSH.
  - PCLW: pc <= {page, 1'b0, pcl_data}; state goes to FLUSH.
  - SLEEP: pc held; state goes to SLEEP.
- In SLEEP, on `en`:
  - `op` is ignored and pc is held.
  - If `wake`=1, state goes to RUN with pc unchanged. The fetched word at pc is valid.
- `stk_cmd` is combinational from state, `en`, `op` and `rst`. It is PUSH or POP only in RUN with `en`=1 and the matching `op`; otherwise it is hold. The stack commits on the same edge as pc.
- Depth, push: `depth` <= min(depth+1, 2). If `depth` was 2, set `stk_ovf`; the stack overwrites its oldest entry.
- Depth, pop: if `depth`=0, set `stk_unf` and keep `depth` at 0, while pc still loads `stk_top`. Otherwise `depth` <= depth-1.
- Increment wraps modulo 2^PC_WIDTH.

## Timing
- Reset values:
  - `pc`=RESET_VEC, state FLUSH, `flush`=1.
  - `depth`=0, `stk_ovf`=0, `stk_unf`=0.
  - `stk_cmd`=hold while `rst`=1.
  - `stk_data`=RESET_VEC+1.
- `rst` has priority over `en`. Asserting it mid-CALL suppresses the push in that cycle.
- With `en`=0, all registers hold and `stk_cmd`=hold.
- Latency: a new pc is visible one edge after the `en` cycle that applies the instruction.
- Every taken branch costs exactly one FLUSH cycle, i.e. two instruction cycles total.
- `stk_data` and `stk_cmd` are valid in the same cycle as the CALL/RET `op`. RET uses the pre-edge `stk_top`.
- A CALL or RET presented during FLUSH or SLEEP has no stack effect and no depth change.

## Test plan
- Reset and first cycle (RESET_VEC=0x7FF):
  - Hold `rst` for 2 cycles: `pc`=0x7FF, `flush`=1, `depth`=0, `stk_cmd`=hold.
  - First `en`: `pc`=0x000, `flush`=0.
- CALL:
  - At `pc`=0x012, apply `page`=01, `target`=0x0A5, CALL: `stk_cmd`=PUSH and `stk_data`=0x013 in that cycle.
  - Next state: `pc`=0x2A5, `flush`=1, `depth`=1.
  - Following `en`: `pc`=0x2A6.
- Overflow and RET:
  - Three CALLs with a flush cycle between each: `depth`=2, and `stk_ovf`=1 after the third.
  - Then RET with `stk_top`=0x150: `stk_cmd`=POP, `pc`=0x150, `depth`=1.
- Underflow:
  - RET at `depth`=0 with `stk_top`=0x033: `pc`=0x033, `stk_unf`=1, `depth`=0.
  - `stk_unf` stays 1 until `rst`.
- SKIP squashes a CALL:
  - SKIP at `pc`=0x040: `pc`=0x041, `flush`=1.
  - CALL presented during the flush: `stk_cmd`=hold, `pc`=0x042, `depth` unchanged.
- PCLW, SLEEP and enable gating:
  - PCLW with `page`=11, `pcl_data`=0x3C: `pc`=0x63C, `flush`=1.
  - Later SLEEP at `pc`=0x100: `pc` holds 0x100 across 5 `en` cycles with `wake`=0.
  - `wake`=1: state goes to RUN, `flush`=0, `pc`=0x100.
  - `en`=0 for 3 cycles: nothing changes.
